// File: rtl/neuraedge_pe_seq_ctrl_pkg.sv
// rtl/neuraedge_pe_seq_ctrl_pkg.sv - shared widths and sequencer state encoding
package neuraedge_pe_seq_ctrl_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_WEIGHT_WIDTH = 8;
  localparam int DEF_ACCUM_WIDTH  = 32;
  localparam int DEF_LEN_WIDTH    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4
  } seq_state_t;

endpackage

// File: rtl/neuraedge_pe_seq_ctrl_if.sv
// rtl/neuraedge_pe_seq_ctrl_if.sv - command, operand, PE and result signals of the sequencer
interface neuraedge_pe_seq_ctrl_if
  import neuraedge_pe_seq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int ACCUM_WIDTH  = DEF_ACCUM_WIDTH,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH
) ();

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [LEN_WIDTH-1:0]    cmd_len;
  logic                    cmd_keep;
  logic                    op_valid;
  logic                    op_ready;
  logic [DATA_WIDTH-1:0]   op_data;
  logic [WEIGHT_WIDTH-1:0] op_weight;
  logic                    pe_enable;
  logic                    pe_mac_clear;
  logic                    pe_accumulate_en;
  logic                    pe_data_valid;
  logic [DATA_WIDTH-1:0]   pe_data;
  logic [WEIGHT_WIDTH-1:0] pe_weight;
  logic [ACCUM_WIDTH-1:0]  pe_accum_in;
  logic                    res_valid;
  logic                    res_ready;
  logic [ACCUM_WIDTH-1:0]  res_data;
  logic                    busy;

  modport master (
    output cmd_valid, cmd_len, cmd_keep, op_valid, op_data, op_weight, pe_accum_in, res_ready,
    input  cmd_ready, op_ready, pe_enable, pe_mac_clear, pe_accumulate_en, pe_data_valid,
           pe_data, pe_weight, res_valid, res_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_keep, op_valid, op_data, op_weight, pe_accum_in, res_ready,
    output cmd_ready, op_ready, pe_enable, pe_mac_clear, pe_accumulate_en, pe_data_valid,
           pe_data, pe_weight, res_valid, res_data, busy
  );

endinterface

// File: rtl/neuraedge_pe_seq_ctrl.sv
// rtl/neuraedge_pe_seq_ctrl.sv - dot-product command sequencer for one NeuraEdge PE
module neuraedge_pe_seq_ctrl
  import neuraedge_pe_seq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int ACCUM_WIDTH  = DEF_ACCUM_WIDTH,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH
) (
  input logic                     clk,
  input logic                     rst,
  neuraedge_pe_seq_ctrl_if.slave  sif
);

  seq_state_t             state_q, state_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic [ACCUM_WIDTH-1:0] res_q;
  logic                   force_clear_q;

  logic cmd_ready_c, op_ready_c, pe_enable_c, mac_clear_c, acc_en_c, data_valid_c, res_valid_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      res_q         <= '0;
      force_clear_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      if (state_q == ST_DRAIN) res_q <= sif.pe_accum_in;
      if (state_q == ST_CLEAR) force_clear_q <= 1'b0;
    end
  end

  // remaining is only ever decremented in RUN, which is entered with a non-zero count
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    cmd_ready_c  = 1'b0;
    op_ready_c   = 1'b0;
    pe_enable_c  = 1'b0;
    mac_clear_c  = 1'b0;
    acc_en_c     = 1'b0;
    data_valid_c = 1'b0;
    res_valid_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_c = 1'b1;
        if (sif.cmd_valid) begin
          remaining_d = sif.cmd_len;
          if (!sif.cmd_keep || force_clear_q) state_d = ST_CLEAR;
          else if (sif.cmd_len != '0)         state_d = ST_RUN;
          else                                state_d = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        mac_clear_c = 1'b1;
        state_d     = (remaining_q != '0) ? ST_RUN : ST_DRAIN;
      end
      ST_RUN: begin
        pe_enable_c  = 1'b1;
        acc_en_c     = 1'b1;
        op_ready_c   = 1'b1;
        data_valid_c = sif.op_valid;
        if (sif.op_valid) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN:  state_d = ST_RESULT;
      ST_RESULT: begin
        res_valid_c = 1'b1;
        if (sif.res_ready) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // every output is forced low for the whole cycle in which rst is asserted
  assign sif.cmd_ready        = cmd_ready_c  & ~rst;
  assign sif.op_ready         = op_ready_c   & ~rst;
  assign sif.pe_enable        = pe_enable_c  & ~rst;
  assign sif.pe_mac_clear     = mac_clear_c  & ~rst;
  assign sif.pe_accumulate_en = acc_en_c     & ~rst;
  assign sif.pe_data_valid    = data_valid_c & ~rst;
  assign sif.pe_data          = rst ? '0 : sif.op_data;
  assign sif.pe_weight        = rst ? '0 : sif.op_weight;
  assign sif.res_valid        = res_valid_c  & ~rst;
  assign sif.res_data         = rst ? '0 : res_q;
  assign sif.busy             = (state_q != ST_IDLE) & ~rst;

endmodule

// File: tb/tb_neuraedge_pe_seq_ctrl.sv
// tb/tb_neuraedge_pe_seq_ctrl.sv - directed self-checking bench with a behavioural PE accumulator
module tb_neuraedge_pe_seq_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   last_beat_cyc;
  int   clr_count;
  int   opr_count;
  logic [31:0] pe_acc;
  logic signed [15:0] prod;

  neuraedge_pe_seq_ctrl_if bus ();

  neuraedge_pe_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .sif (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural PE: signed 8x8 product, sign-extended, wrapping 32-bit accumulate
  assign prod = $signed(bus.pe_data) * $signed(bus.pe_weight);
  assign bus.pe_accum_in = pe_acc;

  initial pe_acc = 32'd0;
  always @(posedge clk) begin
    if (bus.pe_mac_clear)
      pe_acc <= 32'd0;
    else if (bus.pe_enable && bus.pe_accumulate_en && bus.pe_data_valid)
      pe_acc <= pe_acc + {{16{prod[15]}}, prod};
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    last_beat_cyc = -1;
    clr_count     = 0;
    opr_count     = 0;
  end
  always @(negedge clk) begin
    if (bus.op_valid && bus.op_ready) last_beat_cyc = cyc;
    if (bus.pe_mac_clear) clr_count = clr_count + 1;
    if (bus.op_ready) opr_count = opr_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [15:0] len, input logic keep, output int acc_cyc);
    int n = 0;
    acc_cyc = -1;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len;
    bus.cmd_keep  = keep;
    while (!bus.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout: cmd_ready=%0b required 1", bus.cmd_ready);
    end else begin
      acc_cyc = cyc;
      tick();
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic [7:0] w, input int gap);
    int n = 0;
    bus.op_valid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
    bus.op_valid  = 1'b1;
    bus.op_data   = d;
    bus.op_weight = w;
    while (!bus.op_ready && n < 100) begin
      tick();
      n++;
    end
    if (!bus.op_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: op_ready=%0b required 1", bus.op_ready);
    end else begin
      tick();
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic get_result(input int hold, output logic [31:0] data, output int vcyc,
                            output bit stable, output bit leak, output bit crdy_hs);
    int n = 0;
    stable = 1'b1;
    leak = 1'b0;
    crdy_hs = 1'b0;
    data = 32'd0;
    vcyc = -1;
    while (!bus.res_valid && n < 200) begin
      tick();
      n++;
    end
    if (!bus.res_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: res_valid=%0b required 1", bus.res_valid);
      return;
    end
    vcyc = cyc;
    data = bus.res_data;
    if (bus.cmd_ready || bus.op_ready) leak = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!bus.res_valid || bus.res_data !== data) stable = 1'b0;
      if (bus.cmd_ready || bus.op_ready || bus.pe_accumulate_en) leak = 1'b1;
    end
    bus.res_ready = 1'b1;
    #1;
    crdy_hs = bus.cmd_ready;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_len = 16'd3;
    tick();
    tick();
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.op_ready, bus.res_valid, bus.pe_mac_clear} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000",
               {bus.cmd_ready, bus.busy, bus.op_ready, bus.res_valid, bus.pe_mac_clear});
    end
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.res_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_idle: cmd_ready=%0b busy=%0b res_data=%h required 1 0 0",
               bus.cmd_ready, bus.busy, bus.res_data);
    end
  endtask

  task automatic test_basic();
    int acc_cyc, vcyc, clr0;
    logic [31:0] r;
    bit stable, leak, crdy;
    clr0 = clr_count;
    issue_cmd(16'd4, 1'b0, acc_cyc);
    for (int i = 0; i < 4; i++) send_beat(8'(i + 1), 8'(i + 5), 0);
    get_result(0, r, vcyc, stable, leak, crdy);
    checks++;
    if (r !== 32'd70) begin
      errors++;
      $display("FAIL basic_sum: got %0d required 70", r);
    end
    checks++;
    if (last_beat_cyc - acc_cyc !== 5) begin
      errors++;
      $display("FAIL basic_beat_latency: got %0d required 5", last_beat_cyc - acc_cyc);
    end
    checks++;
    if (vcyc - last_beat_cyc !== 2) begin
      errors++;
      $display("FAIL basic_res_latency: got %0d required 2", vcyc - last_beat_cyc);
    end
    checks++;
    if (clr_count - clr0 !== 1) begin
      errors++;
      $display("FAIL basic_clear_pulse: got %0d cycles required 1", clr_count - clr0);
    end
    checks++;
    if (crdy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_cmd_ready_after: at_hs=%0b next=%0b required 0 1", crdy, bus.cmd_ready);
    end
  endtask

  task automatic test_signed();
    int acc_cyc, vcyc;
    logic [31:0] r;
    bit stable, leak, crdy;
    issue_cmd(16'd2, 1'b0, acc_cyc);
    send_beat(8'hFD, 8'h07, 0);
    send_beat(8'h80, 8'h80, 0);
    get_result(0, r, vcyc, stable, leak, crdy);
    checks++;
    if (r !== 32'h0000_3FEB) begin
      errors++;
      $display("FAIL signed_pair: got %h required 00003feb", r);
    end
    issue_cmd(16'd1, 1'b0, acc_cyc);
    send_beat(8'hFD, 8'h07, 0);
    get_result(0, r, vcyc, stable, leak, crdy);
    checks++;
    if (r !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL signed_single: got %h required ffffffeb", r);
    end
  endtask

  task automatic test_keep_chain();
    int acc_cyc, vcyc, clr0;
    logic [31:0] r;
    bit stable, leak, crdy;
    issue_cmd(16'd2, 1'b0, acc_cyc);
    send_beat(8'd1, 8'd1, 0);
    send_beat(8'd2, 8'd2, 0);
    get_result(0, r, vcyc, stable, leak, crdy);
    checks++;
    if (r !== 32'd5) begin
      errors++;
      $display("FAIL chain_first: got %0d required 5", r);
    end
    clr0 = clr_count;
    issue_cmd(16'd1, 1'b1, acc_cyc);
    send_beat(8'd3, 8'd3, 0);
    get_result(0, r, vcyc, stable, leak, crdy);
    checks++;
    if (r !== 32'd14 || clr_count !== clr0) begin
      errors++;
      $display("FAIL chain_keep: got %0d clears=%0d required 14 clears=0", r, clr_count - clr0);
    end
    pulse_reset();
    clr0 = clr_count;
    issue_cmd(16'd1, 1'b1, acc_cyc);
    send_beat(8'd2, 8'd2, 0);
    get_result(0, r, vcyc, stable, leak, crdy);
    checks++;
    if (r !== 32'd4 || clr_count - clr0 !== 1) begin
      errors++;
      $display("FAIL keep_after_reset: got %0d clears=%0d required 4 clears=1", r, clr_count - clr0);
    end
  endtask

  task automatic test_backpressure();
    int acc_cyc, vcyc;
    logic [31:0] r, v0;
    bit stable, leak, crdy;
    issue_cmd(16'd4, 1'b0, acc_cyc);
    send_beat(8'd1, 8'd5, 0);
    v0 = pe_acc;
    tick();
    tick();
    checks++;
    if (pe_acc !== v0 || pe_acc !== 32'd5 || bus.op_ready !== 1'b1 || bus.pe_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: acc=%0d op_ready=%0b dv=%0b required 5 1 0",
               pe_acc, bus.op_ready, bus.pe_data_valid);
    end
    send_beat(8'd2, 8'd6, 0);
    send_beat(8'd3, 8'd7, 2);
    send_beat(8'd4, 8'd8, 0);
    get_result(5, r, vcyc, stable, leak, crdy);
    checks++;
    if (r !== 32'd70 || !stable) begin
      errors++;
      $display("FAIL bp_result: got %0d stable=%0b required 70 stable=1", r, stable);
    end
    checks++;
    if (leak || crdy) begin
      errors++;
      $display("FAIL bp_ready_leak: leak=%0b cmd_ready_at_hs=%0b required 0 0", leak, crdy);
    end
  endtask

  task automatic test_len_zero();
    int acc_cyc, vcyc, opr0, clr0;
    logic [31:0] r;
    bit stable, leak, crdy;
    opr0 = opr_count;
    issue_cmd(16'd0, 1'b0, acc_cyc);
    get_result(0, r, vcyc, stable, leak, crdy);
    checks++;
    if (r !== 32'd0 || opr_count !== opr0) begin
      errors++;
      $display("FAIL len0_clear: got %0d op_ready_cycles=%0d required 0 0", r, opr_count - opr0);
    end
    issue_cmd(16'd4, 1'b0, acc_cyc);
    for (int i = 0; i < 4; i++) send_beat(8'(i + 1), 8'(i + 5), 0);
    get_result(0, r, vcyc, stable, leak, crdy);
    opr0 = opr_count;
    clr0 = clr_count;
    issue_cmd(16'd0, 1'b1, acc_cyc);
    get_result(0, r, vcyc, stable, leak, crdy);
    checks++;
    if (r !== 32'd70 || opr_count !== opr0 || clr_count !== clr0) begin
      errors++;
      $display("FAIL len0_keep: got %0d op_ready=%0d clears=%0d required 70 0 0",
               r, opr_count - opr0, clr_count - clr0);
    end
  endtask

  task automatic test_max_len();
    int acc_cyc;
    issue_cmd(16'hFFFF, 1'b0, acc_cyc);
    for (int i = 0; i < 3; i++) send_beat(8'd1, 8'd1, 0);
    checks++;
    if (bus.op_ready !== 1'b1 || bus.busy !== 1'b1 || bus.res_valid !== 1'b0 || pe_acc !== 32'd3) begin
      errors++;
      $display("FAIL max_len_run: op_ready=%0b busy=%0b res_valid=%0b acc=%0d required 1 1 0 3",
               bus.op_ready, bus.busy, bus.res_valid, pe_acc);
    end
    pulse_reset();
  endtask

  task automatic test_reset_mid_run();
    int acc_cyc, vcyc;
    logic [31:0] r;
    bit stable, leak, crdy;
    issue_cmd(16'd4, 1'b0, acc_cyc);
    send_beat(8'd1, 8'd5, 0);
    send_beat(8'd2, 8'd6, 0);
    bus.op_valid  = 1'b1;
    bus.op_data   = 8'd3;
    bus.op_weight = 8'd7;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.op_ready, bus.busy, bus.pe_enable, bus.pe_data_valid,
         bus.pe_accumulate_en, bus.pe_mac_clear, bus.res_valid} !== 8'b0 ||
        bus.res_data !== 32'd0 || bus.pe_data !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b data=%h required all zero",
               {bus.cmd_ready, bus.op_ready, bus.busy, bus.pe_enable, bus.pe_data_valid,
                bus.pe_accumulate_en, bus.pe_mac_clear, bus.res_valid}, bus.res_data);
    end
    tick();
    rst = 1'b0;
    bus.op_valid = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || pe_acc !== 32'd17) begin
      errors++;
      $display("FAIL rst_mid_idle: busy=%0b cmd_ready=%0b acc=%0d required 0 1 17",
               bus.busy, bus.cmd_ready, pe_acc);
    end
    issue_cmd(16'd1, 1'b1, acc_cyc);
    send_beat(8'd2, 8'd3, 0);
    get_result(0, r, vcyc, stable, leak, crdy);
    checks++;
    if (r !== 32'd6) begin
      errors++;
      $display("FAIL rst_mid_next: got %0d required 6", r);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len = 16'd0;
    bus.cmd_keep = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_data = 8'd0;
    bus.op_weight = 8'd0;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_keep_chain();
    test_backpressure();
    test_len_zero();
    test_max_len();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuraedge_pe_seq_ctrl.md
Name: neuraedge_pe_seq_ctrl

Overview:
Command-driven sequencer for one NeuraEdge processing element (PE). It accepts a dot-product command (length K, clear/keep) and clears the PE accumulator when required. It then streams K signed data/weight pairs into the PE with valid/ready backpressure and returns the final 32-bit accumulator value on a result handshake. It sits between the tile scheduler / operand buffers and a PE instance; the PE is instantiated by the parent, not inside this block.

Parameters:
DATA_WIDTH, 8, operand data width (signed)
WEIGHT_WIDTH, 8, operand weight width (signed)
ACCUM_WIDTH, 32, PE accumulator / result width
LEN_WIDTH, 16, command length field width (max K = 2^LEN_WIDTH-1)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_len  in  LEN_WIDTH  number of operand beats K
cmd_keep  in  1  1 = continue from current accumulator, 0 = clear first
op_valid  in  1  operand beat offered
op_ready  out  1  operand beat accepted when valid&ready
op_data  in  DATA_WIDTH  operand data
op_weight  in  WEIGHT_WIDTH  operand weight
pe_enable  out  1  to PE
pe_mac_clear  out  1  to PE, clears accumulator at next edge
pe_accumulate_en  out  1  to PE
pe_data_valid  out  1  to PE
pe_data  out  DATA_WIDTH  to PE, = op_data
pe_weight  out  WEIGHT_WIDTH  to PE, = op_weight
pe_accum_in  in  ACCUM_WIDTH  from PE accumulator output
res_valid  out  1  result available
res_ready  in  1  result consumed when valid&ready
res_data  out  ACCUM_WIDTH  captured accumulator value
busy  out  1  state != IDLE

Behaviour:
- Reset: clk and rst only; rst synchronous, active-high. Reset takes effect at the next edge, and every output is 0 while rst=1 (cmd_ready gated by !rst). State←IDLE, counter←0, res_data←0, force_clear←1.
- force_clear: set by rst. Cleared after any CLEAR state. While set, cmd_keep is ignored and the command always clears.
- States: IDLE, CLEAR, RUN, DRAIN, RESULT.
- IDLE: cmd_ready=1. On cmd_valid: latch len into remaining; do_clear = !cmd_keep | force_clear. Go to CLEAR if do_clear, else RUN if len≠0, else DRAIN.
- CLEAR (1 cycle): pe_mac_clear=1, pe_enable=0. Next state RUN if len≠0, else DRAIN.
- RUN: pe_enable=1, pe_accumulate_en=1, op_ready=1, pe_data_valid=op_valid. Each accepted beat decrements remaining. When the beat with remaining==1 is accepted, go to DRAIN. op_valid low stalls with no PE update.
- DRAIN (1 cycle): pe_accum_in now holds the final sum. Register it into res_data; go to RESULT.
- RESULT: res_valid=1, res_data stable. On res_ready go to IDLE. The next cmd_ready is one cycle later; no same-cycle bypass.
- Latency: command accepted at cycle T. CLEAR at T+1, first beat at T+2 at the earliest. Last beat accepted at L; res_valid at L+2.
- Outside RUN: op_ready=0, pe_data_valid=0, pe_accumulate_en=0. pe_mac_clear is 1 only in CLEAR.
- Arithmetic is performed by the PE: signed 8×8 product, sign-extended, wraps modulo 2^32. There is no saturation and the controller does not modify the sum.
- Boundary conditions:
  - len=0 with clear: result is 0.
  - len=0 with keep: result is the current accumulator.
  - Max len: counter must not wrap.
  - rst mid-operation: abort immediately. The beat in flight is dropped, a pending result is lost, and the next command is forced to clear.
  - cmd_valid outside IDLE: ignored.

Decomposition:
- Shared header neuraedge_defines.vh holds:
  - state encoding localparams (3-bit: IDLE=0, CLEAR=1, RUN=2, DRAIN=3, RESULT=4)
  - default DATA_WIDTH, WEIGHT_WIDTH, ACCUM_WIDTH, LEN_WIDTH constants, shared with the PE and array top.
- No sub-module. FSM, beat counter and result register stay in one module.

Test Plan:
- Basic: cmd len=4, keep=0; data {1,2,3,4}, weights {5,6,7,8}, no stalls -> res_data=70 (0x46), res_valid exactly 2 cycles after the 4th beat, pe_mac_clear high exactly 1 cycle.
- Signed: len=2; data {0xFD,0x80}, weights {0x07,0x80} -> (-21)+(16384) = 16363 (0x00003FEB); a single beat 0xFD×0x07 -> 0xFFFFFFEB.
- Keep/chain: cmd1 len=2 {1×1, 2×2} -> 5; cmd2 keep=1, len=1 {3×3} -> 14 with no clear pulse. After rst, the first keep=1 command still clears, e.g. a single 2×2 beat -> 4.
- Backpressure: op_valid toggles 1,0,0,1,... and res_ready is held low 5 cycles -> op_ready only in RUN, stalled cycles leave the PE unchanged, res_data stable and equal to the expected sum, cmd_ready low until after the result handshake.
- Length zero: len=0, keep=0 -> res_data=0, no op_ready asserted. len=0, keep=1 after a prior sum of 70 -> res_data=70.
- Reset mid-RUN: rst=1 after 2 of 4 beats -> next cycle all outputs 0, state IDLE. A following keep=1 len=1 {2×3} -> res_data=6.
